// File: rtl/btn_pkg.sv
// btn_pkg: shared debounce state encoding, button indices and op width for btn_conditioner.
package btn_pkg;
    typedef enum logic [1:0] {S_LO, S_WAIT_HI, S_HI, S_WAIT_LO} db_state_t;
    localparam int BTN_UP     = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 3;
    localparam int BTN_CENTER = 4;
    localparam int OP_W       = 3;
endpackage

// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if: raw board pins in, conditioned levels/pulses and ALU op out.
interface btn_conditioner_if
    import btn_pkg::*;
#(
    parameter int N_SW  = 16,
    parameter int N_BTN = 5
);
    logic [N_SW-1:0]  sw_raw;
    logic [N_SW-1:0]  sw_db;
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_db;
    logic [N_BTN-1:0] btn_rise;
    logic [N_BTN-1:0] btn_fall;
    logic [OP_W-1:0]  op;
    modport master (output sw_raw, btn_raw, input sw_db, btn_db, btn_rise, btn_fall, op);
    modport slave  (input sw_raw, btn_raw, output sw_db, btn_db, btn_rise, btn_fall, op);
endinterface

// File: rtl/btn_conditioner_debounce_bit.sv
// debounce_bit: 2-flop synchronizer plus a four-state debounce FSM for one input bit.
module debounce_bit
    import btn_pkg::*;
#(
    parameter int DB_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    logic [1:0]       r_sync;
    db_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_s;
    assign w_s = r_sync[1];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_state <= S_LO;
            r_cnt   <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], din};
            rise   <= 1'b0;
            fall   <= 1'b0;
            unique case (r_state)
                S_LO: if (w_s) begin
                    r_state <= S_WAIT_HI;
                    r_cnt   <= '0;
                end
                S_WAIT_HI: if (!w_s) begin
                    r_state <= S_LO;
                    r_cnt   <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_state <= S_HI;
                    r_cnt   <= '0;
                    level   <= 1'b1;
                    rise    <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                S_HI: if (!w_s) begin
                    r_state <= S_WAIT_LO;
                    r_cnt   <= '0;
                end
                S_WAIT_LO: if (w_s) begin
                    r_state <= S_HI;
                    r_cnt   <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_state <= S_LO;
                    r_cnt   <= '0;
                    level   <= 1'b0;
                    fall    <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            endcase
        end
    end
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: debounced switch/button front end and ALU op derivation.
// Define OP_LATCH_EN to make op a toggle register driven by button presses.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_SW      = 16,
    parameter int N_BTN     = 5,
    parameter int DB_CYCLES = 2_000_000
) (
    input logic         clk,
    input logic         rst,
    btn_conditioner_if.slave bus
);
    logic [N_SW-1:0]  w_sw_db;
    logic [N_SW-1:0]  w_unused_sw_rise;
    logic [N_SW-1:0]  w_unused_sw_fall;
    logic [N_BTN-1:0] w_btn_db;
    logic [N_BTN-1:0] w_btn_rise;
    logic [N_BTN-1:0] w_btn_fall;
    genvar i;
    for (i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (clk),
            .rst   (rst),
            .din   (bus.sw_raw[i]),
            .level (w_sw_db[i]),
            .rise  (w_unused_sw_rise[i]),
            .fall  (w_unused_sw_fall[i])
        );
    end
    for (i = 0; i < N_BTN; i++) begin : g_btn
        debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (clk),
            .rst   (rst),
            .din   (bus.btn_raw[i]),
            .level (w_btn_db[i]),
            .rise  (w_btn_rise[i]),
            .fall  (w_btn_fall[i])
        );
    end
    assign bus.sw_db    = w_sw_db;
    assign bus.btn_db   = w_btn_db;
    assign bus.btn_rise = w_btn_rise;
    assign bus.btn_fall = w_btn_fall;
`ifdef OP_LATCH_EN
    logic [OP_W-1:0] r_op;
    // UP clears and overrides any toggles accepted in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_op <= '0;
        else if (w_btn_rise[BTN_UP]) r_op <= '0;
        else r_op <= r_op ^ {w_btn_rise[BTN_LEFT], w_btn_rise[BTN_CENTER], w_btn_rise[BTN_RIGHT]};
    end
    assign bus.op = r_op;
`else
    assign bus.op = {w_btn_db[BTN_LEFT], w_btn_db[BTN_CENTER], w_btn_db[BTN_RIGHT]};
`endif
endmodule
